mem_access: RTL and testbench

Memory-access stage between the EX/MEM pipeline register and the MEM/WB register. It takes the load/store opcode, effective address and store data produced by execute. It runs a req/ack transaction on the data bus, aligns and sign-extends load data, and generates AdEL/AdES address-error exceptions. It holds the pipeline through `stallreq_o` until the access completes.

---
 rtl/mem_access.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_access.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: load/store stage between EX/MEM and MEM/WB.
// Runs one req/ack bus access per memory op, stalling the pipeline until it
// completes, aligns/extends load data and raises AdEL/AdES on misalignment.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] except_type_i,
  input  logic        flush_i,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_ack_i,
  input  logic [31:0] data_rdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] except_type_o,
  output logic [31:0] bad_vaddr_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_load_c, is_store_c, misaligned_c, access_c;
  logic [3:0]  be_c;
  logic [31:0] bus_wdata_c;
  logic        is_load_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_res;

  // Decode the incoming opcode: class, alignment, byte lanes and store data.
  always_comb begin
    is_load_c    = 1'b0;
    is_store_c   = 1'b0;
    misaligned_c = 1'b0;
    be_c         = 4'b0000;
    bus_wdata_c  = 32'h0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP: begin
        is_load_c = 1'b1;
        be_c      = 4'b0001 << mem_addr_i[1:0];
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        is_load_c    = 1'b1;
        misaligned_c = mem_addr_i[0];
        be_c         = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      EXE_LW_OP: begin
        is_load_c    = 1'b1;
        misaligned_c = |mem_addr_i[1:0];
        be_c         = 4'b1111;
      end
      EXE_SB_OP: begin
        is_store_c  = 1'b1;
        be_c        = 4'b0001 << mem_addr_i[1:0];
        bus_wdata_c = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        is_store_c   = 1'b1;
        misaligned_c = mem_addr_i[0];
        be_c         = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        bus_wdata_c  = {2{reg2_i[15:0]}};
      end
      EXE_SW_OP: begin
        is_store_c   = 1'b1;
        misaligned_c = |mem_addr_i[1:0];
        be_c         = 4'b1111;
        bus_wdata_c  = reg2_i;
      end
      default: ;
    endcase
    // A pending exception or flush from upstream kills the access before issue.
    access_c = (is_load_c | is_store_c) & ~misaligned_c &
               ~flush_i & (except_type_i == 32'h0);
  end

  // Lane-select and extend the captured read word using the latched opcode.
  always_comb begin
    is_load_q = 1'b0;
    load_res  = 32'h0;
    case (lane_q)
      2'd0:    byte_sel = rdata_q[7:0];
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    half_sel = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (op_q)
      EXE_LB_OP:  begin is_load_q = 1'b1; load_res = {{24{byte_sel[7]}}, byte_sel}; end
      EXE_LBU_OP: begin is_load_q = 1'b1; load_res = {24'h0, byte_sel}; end
      EXE_LH_OP:  begin is_load_q = 1'b1; load_res = {{16{half_sel[15]}}, half_sel}; end
      EXE_LHU_OP: begin is_load_q = 1'b1; load_res = {16'h0, half_sel}; end
      EXE_LW_OP:  begin is_load_q = 1'b1; load_res = rdata_q; end
      default: ;
    endcase
  end

  // Next-state logic: issue, wait for ack (remembering flushes), then one DONE cycle.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (access_c) begin
          addr_d  = {mem_addr_i[31:2], 2'b00};
          we_d    = is_store_c;
          be_d    = be_c;
          wdata_d = bus_wdata_c;
          op_d    = aluop_i;
          lane_d  = mem_addr_i[1:0];
          if (data_ack_i) begin
            rdata_d = data_rdata_i;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush_i) kill_d = 1'b1;
        if (data_ack_i) begin
          rdata_d = data_rdata_i;
          // A flushed access still finishes on the bus but skips write-back.
          state_d = (kill_q | flush_i) ? S_IDLE : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      kill_q  <= 1'b0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      op_q    <= 8'h0;
      lane_q  <= 2'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    data_req_o    = 1'b0;
    data_we_o     = 1'b0;
    data_be_o     = 4'h0;
    data_addr_o   = 32'h0;
    data_wdata_o  = 32'h0;
    wd_o          = 5'h0;
    wreg_o        = 1'b0;
    wdata_o       = 32'h0;
    except_type_o = 32'h0;
    bad_vaddr_o   = 32'h0;
    stallreq_o    = 1'b0;
    if (!rst) begin
      wd_o          = wd_i;
      wdata_o       = wdata_i;
      except_type_o = except_type_i;
      case (state_q)
        S_IDLE: begin
          if (is_load_c | is_store_c) begin
            if (misaligned_c) begin
              except_type_o[13] = except_type_i[13] | is_load_c;
              except_type_o[14] = except_type_i[14] | is_store_c;
              bad_vaddr_o       = mem_addr_i;
            end
          end else begin
            wreg_o = wreg_i;
          end
          if (access_c) begin
            data_req_o   = 1'b1;
            stallreq_o   = 1'b1;
            data_we_o    = is_store_c;
            data_be_o    = be_c;
            data_addr_o  = {mem_addr_i[31:2], 2'b00};
            data_wdata_o = bus_wdata_c;
          end
        end
        S_WAIT: begin
          data_req_o   = 1'b1;
          stallreq_o   = 1'b1;
          data_we_o    = we_q;
          data_be_o    = be_q;
          data_addr_o  = addr_q;
          data_wdata_o = wdata_q;
        end
        S_DONE: begin
          wreg_o = is_load_q & wreg_i & ~flush_i & ~kill_q;
          if (is_load_q) wdata_o = load_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors; expected bus requests and write-back results
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_mem_access;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h21;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, except_type_i;
  logic [4:0]  wd_i;
  logic        wreg_i, flush_i;
  logic        data_req_o, data_we_o, data_ack_i;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o;
  logic [31:0] wdata_o, except_type_o, bad_vaddr_o;

  mem_access dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .except_type_i(except_type_i), .flush_i(flush_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_ack_i(data_ack_i), .data_rdata_i(data_rdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .except_type_o(except_type_o), .bad_vaddr_o(bad_vaddr_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_t;

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] exc;
    logic [31:0] bad;
    int          stalls;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   total = 0;
  int   bad = 0;
  int   stall_cnt = 0;
  logic instr_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input logic chk);
    bus_t b;
    b.addr = addr; b.we = we; b.be = be; b.wdata = wdata; b.chk_wdata = chk;
    bus_q.push_back(b);
  endtask

  task automatic push_res(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                          input logic chk, input logic [31:0] exc, input logic [31:0] badv,
                          input int stalls);
    res_t r;
    r.wreg = wreg; r.wd = wd; r.wdata = wdata; r.chk_wdata = chk;
    r.exc = exc; r.bad = badv; r.stalls = stalls;
    res_q.push_back(r);
  endtask

  // Monitor: one bus check per acked request, one result check per non-stall cycle.
  always @(negedge clk) begin
    if (!instr_valid) begin
      stall_cnt = 0;
    end else begin
      if (data_req_o && data_ack_i) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bus_unexpected: got addr %h expected no request", data_addr_o);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          check("bus_addr", data_addr_o, b.addr);
          check("bus_we", {31'h0, data_we_o}, {31'h0, b.we});
          check("bus_be", {28'h0, data_be_o}, {28'h0, b.be});
          if (b.chk_wdata) check("bus_wdata", data_wdata_o, b.wdata);
        end
      end
      if (stallreq_o) begin
        stall_cnt++;
      end else if (res_q.size() == 0) begin
        total++; bad++;
        $display("FAIL res_unexpected: got wreg %b expected no result", wreg_o);
      end else begin
        res_t r;
        r = res_q.pop_front();
        check("res_wreg", {31'h0, wreg_o}, {31'h0, r.wreg});
        check("res_wd", {27'h0, wd_o}, {27'h0, r.wd});
        if (r.chk_wdata) check("res_wdata", wdata_o, r.wdata);
        check("res_except", except_type_o, r.exc);
        check("res_badvaddr", bad_vaddr_o, r.bad);
        check("res_stalls", stall_cnt, r.stalls);
        check("res_req_idle", {31'h0, data_req_o}, 32'h0);
        $display("txn: wd=%0d wreg=%b wdata=%h exc=%h bad=%h stalls=%0d",
                 wd_o, wreg_o, wdata_o, except_type_o, bad_vaddr_o, stall_cnt);
        stall_cnt = 0;
      end
    end
  end

  // Present one EX/MEM instruction and hold it until the stage stops stalling.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] exc, input logic [31:0] rdata,
                        input int ack_dly, input int flush_cyc);
    bit fin;
    bit done;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = wreg;
    wdata_i = wdata; except_type_i = exc; data_rdata_i = rdata;
    instr_valid = 1'b1;
    done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      data_ack_i = (cyc == ack_dly);
      flush_i    = (flush_cyc >= 0) && (cyc >= flush_cyc);
      #1;
      fin = !stallreq_o;
      @(posedge clk); #1;
      if (fin) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL op_timeout: got stall held 40 cycles expected completion");
    end
    data_ack_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    aluop_i = OP_LW; mem_addr_i = 32'h1004; reg2_i = 32'h1111_2222; wd_i = 5'd3;
    wreg_i = 1'b1; wdata_i = 32'h3333_4444; except_type_i = 32'h8; flush_i = 1'b0;
    data_ack_i = 1'b1; data_rdata_i = 32'h5555_6666;
    #2;
    check("rst_req", {31'h0, data_req_o}, 32'h0);
    check("rst_stall", {31'h0, stallreq_o}, 32'h0);
    check("rst_wreg", {31'h0, wreg_o}, 32'h0);
    check("rst_except", except_type_o, 32'h0);
    check("rst_badvaddr", bad_vaddr_o, 32'h0);
    check("rst_wdata", wdata_o, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    aluop_i = OP_NOP; data_ack_i = 1'b0; except_type_i = 32'h0;
    rst = 1'b0;
    @(posedge clk); #1;

    // LW, ack in the issue cycle
    push_bus(32'h1004, 1'b0, 4'b1111, 32'h0, 1'b0);
    push_res(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'h0, 1);
    run_op(OP_LW, 32'h1004, 32'h0, 5'd5, 1'b1, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, -1);

    // LB / LBU from top lane, ack after 3 cycles
    push_bus(32'h1000, 1'b0, 4'b1000, 32'h0, 1'b0);
    push_res(1'b1, 5'd6, 32'hFFFF_FF80, 1'b1, 32'h0, 32'h0, 4);
    run_op(OP_LB, 32'h1003, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0, 32'h8012_3456, 3, -1);
    push_bus(32'h1000, 1'b0, 4'b1000, 32'h0, 1'b0);
    push_res(1'b1, 5'd6, 32'h0000_0080, 1'b1, 32'h0, 32'h0, 4);
    run_op(OP_LBU, 32'h1003, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0, 32'h8012_3456, 3, -1);

    // SH to upper half
    push_bus(32'h2000, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b1);
    push_res(1'b0, 5'd7, 32'h0, 1'b0, 32'h0, 32'h0, 2);
    run_op(OP_SH, 32'h2002, 32'h1234_ABCD, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, 1, -1);

    // Misaligned LW and SH
    push_res(1'b0, 5'd8, 32'h0, 1'b0, 32'h0000_2000, 32'h1002, 0);
    run_op(OP_LW, 32'h1002, 32'h0, 5'd8, 1'b1, 32'h0, 32'h0, 32'h0, -1, -1);
    push_res(1'b0, 5'd9, 32'h0, 1'b0, 32'h0000_4000, 32'h1001, 0);
    run_op(OP_SH, 32'h1001, 32'h0, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, -1, -1);

    // Non-memory pass-through
    push_res(1'b1, 5'd10, 32'h0000_55AA, 1'b1, 32'h0, 32'h0, 0);
    run_op(OP_ADD, 32'h0, 32'h0, 5'd10, 1'b1, 32'h0000_55AA, 32'h0, 32'h0, -1, -1);

    // Upstream exception suppresses an aligned LW
    push_res(1'b0, 5'd11, 32'h0, 1'b0, 32'h0000_0100, 32'h0, 0);
    run_op(OP_LW, 32'h1000, 32'h0, 5'd11, 1'b1, 32'h0, 32'h0000_0100, 32'h0, 0, -1);

    // Flush during WAIT: bus completes, no DONE, no write-back
    push_bus(32'h3000, 1'b0, 4'b1111, 32'h0, 1'b0);
    push_res(1'b0, 5'd12, 32'h0, 1'b0, 32'h0, 32'h0, 4);
    run_op(OP_LW, 32'h3000, 32'h0, 5'd12, 1'b1, 32'h0, 32'h0, 32'h9999_9999, 3, 1);

    // Following access proceeds normally
    push_bus(32'h3008, 1'b0, 4'b1111, 32'h0, 1'b0);
    push_res(1'b1, 5'd13, 32'h1122_3344, 1'b1, 32'h0, 32'h0, 2);
    run_op(OP_LW, 32'h3008, 32'h0, 5'd13, 1'b1, 32'h0, 32'h0, 32'h1122_3344, 1, -1);

    // SB lane 1, LH / LHU lanes, SW
    push_bus(32'h1000, 1'b1, 4'b0010, 32'hABAB_ABAB, 1'b1);
    push_res(1'b0, 5'd14, 32'h0, 1'b0, 32'h0, 32'h0, 1);
    run_op(OP_SB, 32'h1001, 32'h0000_00AB, 5'd14, 1'b1, 32'h0, 32'h0, 32'h0, 0, -1);
    push_bus(32'h1000, 1'b0, 4'b1100, 32'h0, 1'b0);
    push_res(1'b1, 5'd15, 32'hFFFF_8001, 1'b1, 32'h0, 32'h0, 3);
    run_op(OP_LH, 32'h1002, 32'h0, 5'd15, 1'b1, 32'h0, 32'h0, 32'h8001_7777, 2, -1);
    push_bus(32'h1000, 1'b0, 4'b0011, 32'h0, 1'b0);
    push_res(1'b1, 5'd16, 32'h0000_F00D, 1'b1, 32'h0, 32'h0, 1);
    run_op(OP_LHU, 32'h1000, 32'h0, 5'd16, 1'b1, 32'h0, 32'h0, 32'h1234_F00D, 0, -1);
    push_bus(32'h4000, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1);
    push_res(1'b0, 5'd17, 32'h0, 1'b0, 32'h0, 32'h0, 1);
    run_op(OP_SW, 32'h4000, 32'hCAFE_F00D, 5'd17, 1'b1, 32'h0, 32'h0, 32'h0, 0, -1);

    // Flush arriving in DONE blocks the write-back
    push_bus(32'h5000, 1'b0, 4'b1111, 32'h0, 1'b0);
    push_res(1'b0, 5'd18, 32'h0, 1'b0, 32'h0, 32'h0, 1);
    run_op(OP_LW, 32'h5000, 32'h0, 5'd18, 1'b1, 32'h0, 32'h0, 32'h7777_7777, 0, 1);

    // Reset pulsed while in WAIT
    instr_valid = 1'b0;
    aluop_i = OP_LW; mem_addr_i = 32'h6000; except_type_i = 32'h0; data_ack_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait_req", {31'h0, data_req_o}, 32'h1);
    check("wait_stall", {31'h0, stallreq_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_req", {31'h0, data_req_o}, 32'h0);
    check("midrst_stall", {31'h0, stallreq_o}, 32'h0);
    $display("txn: reset during wait req=%b stall=%b", data_req_o, stallreq_o);
    aluop_i = OP_NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // LW after reset completes normally
    push_bus(32'h1004, 1'b0, 4'b1111, 32'h0, 1'b0);
    push_res(1'b1, 5'd19, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'h0, 1);
    run_op(OP_LW, 32'h1004, 32'h0, 5'd19, 1'b1, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, -1);

    instr_valid = 1'b0;
    aluop_i = OP_NOP;
    @(posedge clk); #1;
    check("bus_q_left", bus_q.size(), 32'h0);
    check("res_q_left", res_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
